// File: rtl/nx_mimosa_pkg_v2.sv
// Shared fixed-point types, adaptive-Q constants and scheduler state encoding
// for the IMM track scheduler.
package nx_mimosa_pkg_v2;

    localparam int MAX_TARGETS = 8;

    // Q15.16 signed fixed point
    typedef logic signed [31:0] fp_t;

    localparam fp_t FP_ONE            = 32'sh0001_0000;
    // chi-square 95% point for 3 degrees of freedom (7.815)
    localparam fp_t CHI2_THRESHOLD    = 32'sh0007_D0A4;
    localparam fp_t Q_INCREASE_FACTOR = 32'sh0001_8000;  // 1.5
    localparam fp_t Q_DECREASE_FACTOR = 32'sh0000_F333;  // ~0.95
    localparam fp_t Q_MIN_SCALE       = 32'sh0000_199A;  // ~0.1
    localparam fp_t Q_MAX_SCALE       = 32'sh0005_0000;  // 5.0

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_GRANT  = 5'b00010,
        S_START  = 5'b00100,
        S_WAIT   = 5'b01000,
        S_UPDATE = 5'b10000
    } sched_state_t;

    // Q15.16 multiply: full 64-bit signed product, fraction bits truncated
    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return fp_t'(prod >>> 16);
    endfunction

    function automatic fp_t fp_clamp(input fp_t v, input fp_t lo, input fp_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/nx_mimosa_track_sched_if.sv
// Requester and filter-engine handshake bundle for nx_mimosa_track_sched.
// master = scheduler side, slave = requesters plus IMM engine.
interface nx_mimosa_track_sched_if
    import nx_mimosa_pkg_v2::*;
#(
    parameter int N_TGT = MAX_TARGETS
);
    localparam int IDW = (N_TGT > 1) ? $clog2(N_TGT) : 1;

    logic [N_TGT-1:0] req_valid;
    logic [N_TGT-1:0] req_ready;
    logic             eng_start;
    logic [IDW-1:0]   eng_tgt_id;
    fp_t              eng_q_scale;
    logic             eng_done;
    fp_t              eng_nis;
    logic             eng_abort;

    modport master (
        input  req_valid, eng_done, eng_nis,
        output req_ready, eng_start, eng_tgt_id, eng_q_scale, eng_abort
    );

    modport slave (
        output req_valid, eng_done, eng_nis,
        input  req_ready, eng_start, eng_tgt_id, eng_q_scale, eng_abort
    );

endinterface

// File: rtl/nx_mimosa_rr_arb.sv
// Combinational round-robin picker: first set request searching upward,
// wrapping, starting one past the pointer.
module nx_mimosa_rr_arb #(
    parameter int N = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    int w_best;
    int w_dist;

    // pick the requester with the smallest wrapped distance from ptr+1
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        w_best = N;
        w_dist = 0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + 2 * N - 1 - int'(i_ptr)) % N;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/nx_mimosa_track_sched.sv
// Round-robin scheduler sharing one IMM filter engine among N_TGT tracks,
// with per-target adaptive Q scaling driven by the returned NIS.
// Optional engine watchdog: define NX_SCHED_WATCHDOG_EN.
module nx_mimosa_track_sched
    import nx_mimosa_pkg_v2::*;
#(
    parameter int N_TGT      = MAX_TARGETS,
    parameter int WDT_CYCLES = 1024
)(
    input  logic                    clk,
    input  logic                    rst_n,
    nx_mimosa_track_sched_if.master bus,
    output logic                    sched_idle,
    output logic [7:0]              timeout_cnt
);
    localparam int IDW = (N_TGT > 1) ? $clog2(N_TGT) : 1;

    sched_state_t     r_state, w_next;
    logic [N_TGT-1:0] r_sel_oh, w_arb_gnt;
    logic [IDW-1:0]   r_sel, r_last, r_tgt, w_arb_idx;
    logic             w_arb_any;
    fp_t              r_q_scale [N_TGT];
    fp_t              r_qout, r_nis, w_q_new;
    logic             w_wdt_expire;

    nx_mimosa_rr_arb #(.N(N_TGT)) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_last),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state: done beats a coincident watchdog expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_arb_any) w_next = S_GRANT;
            S_GRANT:  w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done)      w_next = S_UPDATE;
                else if (w_wdt_expire) w_next = S_IDLE;
            end
            S_UPDATE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // adaptive Q step: NIS equal to the threshold counts as a decrease
    assign w_q_new = fp_clamp(
        fp_mul(r_q_scale[r_tgt],
               (r_nis > CHI2_THRESHOLD) ? Q_INCREASE_FACTOR : Q_DECREASE_FACTOR),
        Q_MIN_SCALE, Q_MAX_SCALE);

    // selection, launch parameters, NIS capture and per-target Q table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= '0;
            r_sel_oh <= '0;
            r_last   <= IDW'(N_TGT - 1);
            r_tgt    <= '0;
            r_qout   <= '0;
            r_nis    <= '0;
            for (int i = 0; i < N_TGT; i++) r_q_scale[i] <= FP_ONE;
        end else begin
            case (r_state)
                S_IDLE: if (w_arb_any) begin
                    r_sel    <= w_arb_idx;
                    r_sel_oh <= w_arb_gnt;
                end
                S_GRANT: begin
                    r_tgt  <= r_sel;
                    r_qout <= r_q_scale[r_sel];
                end
                S_START:  r_last <= r_tgt;
                S_WAIT:   if (bus.eng_done) r_nis <= bus.eng_nis;
                S_UPDATE: r_q_scale[r_tgt] <= w_q_new;
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == S_GRANT) ? r_sel_oh : '0;
    assign bus.eng_start   = (r_state == S_START);
    assign bus.eng_tgt_id  = r_tgt;
    assign bus.eng_q_scale = r_qout;
    assign sched_idle      = (r_state == S_IDLE);

`ifdef NX_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(WDT_CYCLES + 1);

    logic [WDW-1:0] r_wdt;
    logic [7:0]     r_timeout;

    // wait-cycle counter cleared at launch; expiry count saturates at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt     <= '0;
            r_timeout <= '0;
        end else begin
            if (r_state == S_START)     r_wdt <= '0;
            else if (r_state == S_WAIT) r_wdt <= r_wdt + WDW'(1);
            if (w_wdt_expire && (r_timeout != 8'hFF)) r_timeout <= r_timeout + 8'd1;
        end
    end

    assign w_wdt_expire  = (r_state == S_WAIT) && !bus.eng_done &&
                           (r_wdt == WDW'(WDT_CYCLES - 1));
    assign bus.eng_abort = w_wdt_expire;
    assign timeout_cnt   = r_timeout;
`else
    assign w_wdt_expire  = 1'b0;
    assign bus.eng_abort = 1'b0;
    assign timeout_cnt   = '0;
`endif

endmodule

// File: tb/tb_nx_mimosa_track_sched.sv
// Directed scoreboard bench for nx_mimosa_track_sched (8 targets).
module tb_nx_mimosa_track_sched;

    typedef struct {
        int          id;
        logic [31:0] scale;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sched_idle;
    logic [7:0]  timeout_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic signed [31:0] model [8];

    nx_mimosa_track_sched_if #(.N_TGT(8)) bus ();

    nx_mimosa_track_sched #(.N_TGT(8), .WDT_CYCLES(1024)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .sched_idle  (sched_idle),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // reference adaptive-Q step in wide integer arithmetic
    function automatic logic signed [31:0] m_step(input logic signed [31:0] s,
                                                  input logic signed [31:0] nis);
        longint p;
        p = longint'(s) * ((nis > 32'sh0007_D0A4) ? 64'sd98304 : 64'sd62259);
        p = p >>> 16;
        if (p < 64'sd6554) p = 64'sd6554;
        else if (p > 64'sd327680) p = 64'sd327680;
        return 32'(p);
    endfunction

    // wait for grant, check it against the scoreboard, then check the launch
    task automatic launch(input bit drop, output int wait_n, output exp_t e,
                          output logic [31:0] obs_scale);
        int n;
        n = 0;
        @(negedge clk);
        while ((bus.req_ready == '0) && (n < 16)) begin
            @(negedge clk);
            n++;
        end
        wait_n = n;
        e = sb.pop_front();
        chk("grant_seen", 64'(n < 16), 1);
        chk("req_ready", 64'(bus.req_ready), 64'(1) << e.id);
        chk("req_ready_onehot", 64'($onehot(bus.req_ready)), 1);
        @(posedge clk);
        #1;
        if (drop) bus.req_valid[e.id] = 1'b0;
        @(negedge clk);
        obs_scale = bus.eng_q_scale;
        chk("eng_start", 64'(bus.eng_start), 1);
        chk("eng_tgt_id", 64'(bus.eng_tgt_id), 64'(e.id));
        chk("eng_q_scale", 64'(bus.eng_q_scale), 64'(e.scale));
    endtask

    task automatic finish_txn(input exp_t e, input logic signed [31:0] nis, input int dly);
        repeat (dly) @(posedge clk);
        #1;
        bus.eng_done = 1'b1;
        bus.eng_nis  = nis;
        @(posedge clk);
        #1;
        bus.eng_done = 1'b0;
        @(posedge clk);
        #1;
        model[e.id] = m_step(model[e.id], nis);
    endtask

    task automatic push(input int id, input logic [31:0] scale);
        sb.push_back('{id: id, scale: scale});
    endtask

    initial begin
        int          wn;
        exp_t        e;
        logic [31:0] obs, prev;
        int          n;
        logic        seen;
        logic signed [31:0] nis_tab [9];

        nis_tab = '{32'sh0010_0000, 32'sh0, 32'sh0007_D0A4, 32'sh0007_D0A5,
                    32'sh0008_0000, 32'sh0, 32'sh0010_0000, 32'sh0007_D0A3,
                    32'sh0010_0000};
        for (int i = 0; i < 8; i++) model[i] = 32'sh0001_0000;
        bus.req_valid = '0;
        bus.eng_done  = 1'b0;
        bus.eng_nis   = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 0);
        chk("rst_eng_start", 64'(bus.eng_start), 0);
        chk("rst_eng_tgt_id", 64'(bus.eng_tgt_id), 0);
        chk("rst_eng_q_scale", 64'(bus.eng_q_scale), 0);
        chk("rst_eng_abort", 64'(bus.eng_abort), 0);
        chk("rst_timeout_cnt", 64'(timeout_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 64'(sched_idle), 1);

        // stray done while idle must be ignored
        @(posedge clk);
        #1;
        bus.eng_done = 1'b1;
        bus.eng_nis  = 32'sh0010_0000;
        @(posedge clk);
        #1 bus.eng_done = 1'b0;
        @(negedge clk);
        chk("idle_after_stray_done", 64'(sched_idle), 1);

        // single requester 3: latency and first update
        @(posedge clk);
        #1 bus.req_valid[3] = 1'b1;
        push(3, 32'h0001_0000);
        launch(1'b1, wn, e, obs);
        chk("grant_latency", 64'(wn), 1);
        finish_txn(e, 32'sh0008_0000, 3);

        // target 0 climbs to the upper clamp and stays there
        for (int k = 0; k < 6; k++) begin
            logic [31:0] lit [6];
            lit = '{32'h0001_0000, 32'h0001_8000, 32'h0002_4000,
                    32'h0003_6000, 32'h0005_0000, 32'h0005_0000};
            bus.req_valid[0] = 1'b1;
            push(0, lit[k]);
            launch(1'b1, wn, e, obs);
            finish_txn(e, 32'sh0010_0000, 2);
        end

        // target 3 carries the increase from its first update
        bus.req_valid[3] = 1'b1;
        push(3, 32'h0001_8000);
        launch(1'b1, wn, e, obs);
        finish_txn(e, 32'sh0, 2);

        // target 1 decays to the lower clamp
        prev = 32'h0001_0000;
        for (int k = 0; k < 50; k++) begin
            bus.req_valid[1] = 1'b1;
            push(1, model[1]);
            launch(1'b1, wn, e, obs);
            if (k == 1) chk("t1_first_decrease", 64'(obs), 64'h0000_F333);
            if (k > 0) chk("t1_monotonic", 64'(obs <= prev), 1);
            prev = obs;
            finish_txn(e, 32'sh0, 1);
        end
        bus.req_valid[1] = 1'b1;
        push(1, 32'h0000_199A);
        launch(1'b1, wn, e, obs);
        finish_txn(e, 32'sh0, 1);

        // reset in the middle of WAIT
        bus.req_valid[5] = 1'b1;
        push(5, model[5]);
        launch(1'b1, wn, e, obs);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("wrst_req_ready", 64'(bus.req_ready), 0);
        chk("wrst_eng_start", 64'(bus.eng_start), 0);
        chk("wrst_eng_tgt_id", 64'(bus.eng_tgt_id), 0);
        chk("wrst_eng_q_scale", 64'(bus.eng_q_scale), 0);
        chk("wrst_eng_abort", 64'(bus.eng_abort), 0);
        chk("wrst_timeout_cnt", 64'(timeout_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 32'sh0001_0000;
        @(negedge clk);
        chk("wrst_idle", 64'(sched_idle), 1);

        // all eight requesting: fair rotation starting at 0
        @(posedge clk);
        #1 bus.req_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            push(i % 8, model[i % 8]);
            launch(1'b0, wn, e, obs);
            finish_txn(e, nis_tab[i], 5);
        end
        bus.req_valid = '0;

`ifdef NX_SCHED_WATCHDOG_EN
        // engine hang: abort after the watchdog limit, Q left alone
        @(posedge clk);
        #1 bus.req_valid[2] = 1'b1;
        push(2, model[2]);
        launch(1'b1, wn, e, obs);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.eng_abort && (n < 1100));
        chk("wdt_abort_cycle", 64'(n), 1024);
        @(negedge clk);
        chk("wdt_abort_single", 64'(bus.eng_abort), 0);
        chk("wdt_timeout_cnt", 64'(timeout_cnt), 1);
        chk("wdt_idle", 64'(sched_idle), 1);
        @(posedge clk);
        #1 bus.req_valid[2] = 1'b1;
        push(2, model[2]);
        launch(1'b1, wn, e, obs);
        finish_txn(e, 32'sh0010_0000, 3);

        // done in the very cycle of expiry wins
        bus.req_valid[2] = 1'b1;
        push(2, model[2]);
        launch(1'b1, wn, e, obs);
        @(posedge clk);
        repeat (1023) @(posedge clk);
        #1;
        bus.eng_done = 1'b1;
        bus.eng_nis  = 32'sh0010_0000;
        @(negedge clk);
        chk("wdt_tie_no_abort", 64'(bus.eng_abort), 0);
        @(posedge clk);
        #1 bus.eng_done = 1'b0;
        @(posedge clk);
        #1;
        model[2] = m_step(model[2], 32'sh0010_0000);
        @(negedge clk);
        chk("wdt_tie_timeout_cnt", 64'(timeout_cnt), 1);
        @(posedge clk);
        #1 bus.req_valid[2] = 1'b1;
        push(2, model[2]);
        launch(1'b1, wn, e, obs);
        finish_txn(e, 32'sh0, 2);
`else
        // without the watchdog WAIT only exits on done
        @(posedge clk);
        #1 bus.req_valid[2] = 1'b1;
        push(2, model[2]);
        launch(1'b1, wn, e, obs);
        seen = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            seen = seen | bus.eng_abort | sched_idle;
        end
        chk("nowdt_stays_waiting", 64'(seen), 0);
        chk("nowdt_timeout_cnt", 64'(timeout_cnt), 0);
        finish_txn(e, 32'sh0010_0000, 1);
        bus.req_valid[2] = 1'b1;
        push(2, model[2]);
        launch(1'b1, wn, e, obs);
        finish_txn(e, 32'sh0, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nx_mimosa_track_sched.md
NX_MIMOSA_TRACK_SCHED -- requirements
Module: nx_mimosa_track_sched

Interface
REQ-001 SHALL have parameter N_TGT, default MAX_TARGETS (8): number of track requesters sharing one IMM filter engine.
REQ-002 SHALL have parameter WDT_CYCLES, default 1024: engine-completion watchdog limit in clk cycles.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, N_TGT: per-target measurement-pending flags, level, held until granted.
REQ-006 SHALL have port req_ready, output, N_TGT: one-hot, single-cycle grant to the selected target.
REQ-007 SHALL have port eng_start, output, 1: single-cycle engine launch pulse.
REQ-008 SHALL have port eng_tgt_id, output, $clog2(N_TGT): target index for the launched update.
REQ-009 SHALL have port eng_q_scale, output, 32 (fp_t Q15.16): adaptive Q multiplier for the launched target.
REQ-010 SHALL have port eng_done, input, 1: single-cycle engine completion pulse.
REQ-011 SHALL have port eng_nis, input, 32 (fp_t): normalized innovation squared, valid with eng_done.
REQ-012 SHALL have port eng_abort, output, 1: single-cycle abort pulse to the engine.
REQ-013 SHALL have port sched_idle, output, 1: high when the FSM is in IDLE.
REQ-014 SHALL have port timeout_cnt, output, 8: saturating watchdog-expiry count.

Function
REQ-015 FSM states: IDLE, GRANT, START, WAIT, UPDATE; encoded one-hot.
REQ-016 IDLE: if any req_valid, select the first set bit searching upward, wrapping, from last_grant+1; go to GRANT; otherwise stay.
REQ-017 GRANT: assert req_ready[sel] for exactly one cycle; latch sel into eng_tgt_id and q_scale[sel] into eng_q_scale; go to START.
REQ-018 START: assert eng_start for one cycle; clear watchdog counter; update last_grant=sel; go to WAIT.
REQ-019 Latency: req_valid seen in IDLE at cycle N -> req_ready at N+1 -> eng_start at N+2.
REQ-020 WAIT: on eng_done, capture eng_nis and go to UPDATE; eng_done in any other state SHALL be ignored.
REQ-021 UPDATE: if nis > CHI2_THRESHOLD, scale = fp_mul(scale, Q_INCREASE_FACTOR), else scale = fp_mul(scale, Q_DECREASE_FACTOR); nis == threshold counts as decrease.
REQ-022 The UPDATE result SHALL be clamped to [Q_MIN_SCALE, Q_MAX_SCALE] via fp_clamp, written to q_scale[eng_tgt_id]; next state IDLE.
REQ-023 fp_mul SHALL truncate (no rounding); intermediate product 64-bit signed.
REQ-024 Requests deasserted before grant SHALL simply not be selected; no state is kept for them.
REQ-025 eng_tgt_id and eng_q_scale SHALL hold their values from GRANT until the next GRANT.

Reset
REQ-026 On rst_n low, all outputs SHALL be 0, state IDLE, last_grant = N_TGT-1 (first grant searches from index 0), every q_scale entry = FP_ONE (0x0001_0000), timeout_cnt = 0.
REQ-027 Reset asserted mid-WAIT SHALL abandon the update without emitting eng_abort; the engine is reset by the same rst_n.

Configuration
REQ-028 Macro NX_SCHED_WATCHDOG_EN defined: in WAIT, a counter increments each cycle; on reaching WDT_CYCLES without eng_done, pulse eng_abort, increment timeout_cnt (saturate at 255), leave q_scale unchanged, return to IDLE.
REQ-029 If eng_done arrives in the same cycle the counter expires, eng_done SHALL win.
REQ-030 Macro undefined: no counter; WAIT exits only on eng_done; eng_abort and timeout_cnt tied to 0.

Structure
REQ-031 CHI2_THRESHOLD, Q_INCREASE_FACTOR, Q_DECREASE_FACTOR, Q_MIN/MAX_SCALE, fp_t, fp_mul, fp_clamp and a sched_state_t enum SHALL live in nx_mimosa_pkg_v2.
REQ-032 Round-robin selection SHALL be a sub-module nx_mimosa_rr_arb (N inputs, pointer in, one-hot and index out, combinational).

Verification
REQ-033 Target 3 only requests at cycle 0 -> req_ready=0x08 at 1, eng_start at 2 with id 3, scale 0x0001_0000; done with nis 0x0008_0000 -> q_scale[3]=0x0001_8000.
REQ-034 All 8 requests held constantly, done 5 cycles after each start -> grants in order 0,1,...,7,0; each req_ready one-hot.
REQ-035 Target 0 repeatedly nis 0x0010_0000 -> scales 0x18000, 0x24000, 0x36000, then clamp 0x0005_0000, held thereafter.
REQ-036 Target 1 repeatedly nis 0 -> first 0xF333, monotonically decreasing, clamps at 0x0000_199A.
REQ-037 With NX_SCHED_WATCHDOG_EN, no eng_done for 1024 cycles -> eng_abort pulse, timeout_cnt=1, q_scale unchanged; done coincident with expiry -> normal update, no abort.
REQ-038 rst_n low during WAIT -> all outputs 0, sched_idle=1 after release, all q_scale=0x0001_0000, next grant starts at index 0.
